// File: rtl/instr_word_assembler.sv
// Packs MIPS R/I/J fields into instruction words and streams them
// into instruction memory at sequential word addresses.
module instr_word_assembler #(
  parameter int          ADDR_W     = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        fmt,
  input  logic [5:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       immi,
  input  logic [25:0]       immj,
  input  logic [31:0]       raw,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   words_written,
  output logic              done
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);
  localparam logic [ADDR_W:0] LAST_IDX =
    (ADDR_W+1)'((1 << ADDR_W) - 1);

  logic [1:0]      state;
  logic [31:0]     fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic [ADDR_W:0] accepted;
  logic [ADDR_W:0] written;
  logic [31:0]     word;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // accepted MSB set means the whole address space is claimed
  assign in_ready = (state == S_LOAD) && !full
                    && !accepted[ADDR_W];
  assign mem_we   = (state != S_DONE) && !empty;

  assign push = in_valid && in_ready;
  assign pop  = mem_we && mem_ready;

  assign mem_wdata     = fifo_q[rd_ptr];
  assign mem_addr      = BASE_ADDR + (32'(written) << 2);
  assign words_written = written;
  assign done          = (state == S_DONE);

  always_comb begin
    word = raw;
    unique case (1'b1)
      fmt == 2'b00: word = {op, rs, rt, rd, shamt, funct};
      fmt == 2'b01: word = {op, rs, rt, immi};
      fmt == 2'b10: word = {op, immj};
      default:      word = raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_LOAD;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      accepted <= '0;
      written  <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        accepted <= accepted + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        written <= written + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      unique case (1'b1)
        state == S_LOAD: begin
          if (push && (in_last || accepted == LAST_IDX)) begin
            state <= S_DRAIN;
          end
        end
        state == S_DRAIN: begin
          if (pop && count == ONE_CNT) begin
            state <= S_DONE;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_word_assembler.sv
// Directed bench for instr_word_assembler: encoding, streaming,
// backpressure, capacity, mid-stream reset and push/pop overlap.
module tb_instr_word_assembler;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_last;
  logic [1:0]  fmt;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] immi;
  logic [25:0] immj;
  logic [31:0] raw;
  logic        mem_ready;

  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  words_written;
  logic        done;

  logic        c_in_ready;
  logic        c_mem_we;
  logic [31:0] c_mem_addr;
  logic [31:0] c_mem_wdata;
  logic [2:0]  c_words_written;
  logic        c_done;

  int checks = 0;
  int fails  = 0;

  instr_word_assembler dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .fmt(fmt), .op(op),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .immi(immi), .immj(immj), .raw(raw),
    .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .words_written(words_written), .done(done)
  );

  instr_word_assembler #(.ADDR_W(2)) dut_c (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(c_in_ready),
    .in_last(in_last), .fmt(fmt), .op(op),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .immi(immi), .immj(immj), .raw(raw),
    .mem_we(c_mem_we), .mem_ready(mem_ready),
    .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata),
    .words_written(c_words_written), .done(c_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] f, input logic [5:0] o,
                       input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [4:0] sh,
                       input logic [5:0] fn, input logic [15:0] ii,
                       input logic [25:0] ij, input logic [31:0] rw,
                       input logic last);
    in_valid = 1'b1;
    fmt = f; op = o; rs = s; rt = t; rd = d; shamt = sh;
    funct = fn; immi = ii; immj = ij; raw = rw;
    in_last = last;
  endtask

  task automatic set_raw(input logic [31:0] w, input logic last);
    drive(2'b11, 6'h3f, 5'h1f, 5'h1f, 5'h1f, 5'h1f, 6'h3f,
          16'hffff, 26'h3ffffff, w, last);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (mem_we !== 1'b0) begin
      fails++; $display("FAIL reset_mem_we: got %b want 0", mem_we);
    end
    checks++;
    if (mem_addr !== 32'h0) begin
      fails++; $display("FAIL reset_addr: got %h want 0", mem_addr);
    end
    checks++;
    if (words_written !== 9'd0) begin
      fails++; $display("FAIL reset_ww: got %0d want 0", words_written);
    end
    checks++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL reset_done: got %b want 0", done);
    end
  endtask

  task automatic test_rtype();
    do_reset();
    mem_ready = 1'b1;
    drive(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20,
          16'hbeef, 26'h155_5555, 32'h1111_1111, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1) begin
      fails++; $display("FAIL rtype_we: got %b want 1", mem_we);
    end
    checks++;
    if (mem_wdata !== 32'h0022_1820) begin
      fails++; $display("FAIL rtype_wdata: got %h want 00221820", mem_wdata);
    end
    checks++;
    if (mem_addr !== 32'h0) begin
      fails++; $display("FAIL rtype_addr: got %h want 0", mem_addr);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL rtype_drain_ready: got %b want 0", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      fails++; $display("FAIL rtype_done: got %b want 1", done);
    end
    checks++;
    if (words_written !== 9'd1) begin
      fails++; $display("FAIL rtype_ww: got %0d want 1", words_written);
    end
    checks++;
    if (mem_we !== 1'b0) begin
      fails++; $display("FAIL rtype_done_we: got %b want 0", mem_we);
    end
  endtask

  task automatic test_mixed();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h2008_0005;
    exp_w[1] = 32'h0800_0010;
    exp_w[2] = 32'hdead_beef;
    do_reset();
    mem_ready = 1'b1;
    drive(2'b01, 6'h08, 5'd0, 5'd8, 5'd7, 5'd9, 6'h3f,
          16'h0005, 26'h3ff_ffff, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_wdata !== exp_w[k]) begin
        fails++;
        $display("FAIL mixed_word%0d: got we=%b %h want %h",
                 k, mem_we, mem_wdata, exp_w[k]);
      end
      checks++;
      if (mem_addr !== 32'(4 * k)) begin
        fails++;
        $display("FAIL mixed_addr%0d: got %h want %h",
                 k, mem_addr, 32'(4 * k));
      end
      if (k == 0)
        drive(2'b10, 6'd2, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3f,
              16'hffff, 26'h10, 32'h0, 1'b0);
      else if (k == 1)
        drive(2'b11, 6'h3f, 5'd1, 5'd1, 5'd1, 5'd1, 6'h01,
              16'h1234, 26'h1, 32'hdead_beef, 1'b1);
      else
        in_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || words_written !== 9'd3) begin
      fails++;
      $display("FAIL mixed_done: got done=%b ww=%0d want 1 3",
               done, words_written);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] bp_w [5];
    int idx;
    int wr;
    logic acc;
    logic got_done;
    for (int i = 0; i < 5; i++) bp_w[i] = 32'ha5a5_0000 + 32'(i);
    do_reset();
    idx = 0;
    wr = 0;
    got_done = 1'b0;
    for (int c = 0; c < 30 && !got_done; c++) begin
      mem_ready = (c >= 6);
      if (idx < 5) set_raw(bp_w[idx], idx == 4);
      else in_valid = 1'b0;
      acc = in_valid && in_ready;
      if (c >= 1 && c < 6) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h0
            || mem_wdata !== bp_w[0]) begin
          fails++;
          $display("FAIL bp_hold c%0d: got we=%b %h@%h want %h@0",
                   c, mem_we, mem_wdata, mem_addr, bp_w[0]);
        end
      end
      if (c == 5) begin
        checks++;
        if (idx !== 4 || in_ready !== 1'b0) begin
          fails++;
          $display("FAIL bp_full: got acc=%0d ready=%b want 4 0",
                   idx, in_ready);
        end
      end
      if (mem_we && mem_ready) begin
        checks++;
        if (wr >= 5) begin
          fails++; $display("FAIL bp_extra_write: got %0d want 5", wr + 1);
        end else if (mem_wdata !== bp_w[wr]
                     || mem_addr !== 32'(4 * wr)) begin
          fails++;
          $display("FAIL bp_write%0d: got %h@%h want %h@%h",
                   wr, mem_wdata, mem_addr, bp_w[wr], 32'(4 * wr));
        end
        wr++;
      end
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
      got_done = done;
    end
    in_valid = 1'b0;
    checks++;
    if (!got_done || wr !== 5 || words_written !== 9'd5) begin
      fails++;
      $display("FAIL bp_end: got done=%b wr=%0d ww=%0d want 1 5 5",
               got_done, wr, words_written);
    end
  endtask

  task automatic test_capacity();
    int acc;
    int cw;
    logic [31:0] last_addr;
    do_reset();
    acc = 0;
    cw = 0;
    last_addr = 32'hffff_ffff;
    for (int c = 0; c < 12; c++) begin
      mem_ready = 1'b1;
      set_raw(32'h7000_0000 + 32'(c), 1'b0);
      if (c_in_ready) acc++;
      if (c_mem_we && mem_ready) begin
        last_addr = c_mem_addr;
        cw++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (acc !== 4) begin
      fails++; $display("FAIL cap_accepted: got %0d want 4", acc);
    end
    checks++;
    if (cw !== 4 || c_words_written !== 3'd4) begin
      fails++;
      $display("FAIL cap_writes: got %0d ww=%0d want 4", cw, c_words_written);
    end
    checks++;
    if (c_in_ready !== 1'b0) begin
      fails++; $display("FAIL cap_ready: got %b want 0", c_in_ready);
    end
    checks++;
    if (c_done !== 1'b1) begin
      fails++; $display("FAIL cap_done: got %b want 1", c_done);
    end
    checks++;
    if (last_addr !== 32'hc) begin
      fails++; $display("FAIL cap_last_addr: got %h want c", last_addr);
    end
  endtask

  task automatic test_reset_mid();
    int writes;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_raw(32'hbad0_0000 + 32'(k), 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1) begin
      fails++; $display("FAIL rmid_buffered: got we=%b want 1", mem_we);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || words_written !== 9'd0) begin
      fails++;
      $display("FAIL rmid_cleared: got we=%b ww=%0d want 0 0",
               mem_we, words_written);
    end
    reset = 1'b0;
    mem_ready = 1'b1;
    set_raw(32'h1234_5678, 1'b1);
    writes = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (done) break;
      if (mem_we) begin
        checks++;
        if (mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h0) begin
          fails++;
          $display("FAIL rmid_write: got %h@%h want 12345678@0",
                   mem_wdata, mem_addr);
        end
        writes++;
      end
    end
    checks++;
    if (writes !== 1 || done !== 1'b1 || words_written !== 9'd1) begin
      fails++;
      $display("FAIL rmid_end: got writes=%0d done=%b ww=%0d want 1 1 1",
               writes, done, words_written);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] sb [$];
    logic [31:0] w;
    int writes;
    logic got_done;
    do_reset();
    writes = 0;
    got_done = 1'b0;
    for (int k = 0; k < 40 && !got_done; k++) begin
      mem_ready = (k >= 2);
      if (k < 12) begin
        w = 32'hc0de_0000 + 32'(k);
        set_raw(w, k == 11);
      end else begin
        in_valid = 1'b0;
      end
      if (k >= 2 && k < 12) begin
        checks++;
        if (in_ready !== 1'b1 || mem_we !== 1'b1) begin
          fails++;
          $display("FAIL b2b_flow c%0d: got ready=%b we=%b want 1 1",
                   k, in_ready, mem_we);
        end
      end
      if (mem_we && mem_ready) begin
        checks++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL b2b_extra: got %h want none", mem_wdata);
        end else begin
          w = sb.pop_front();
          if (mem_wdata !== w || mem_addr !== 32'(4 * writes)) begin
            fails++;
            $display("FAIL b2b_write%0d: got %h@%h want %h@%h",
                     writes, mem_wdata, mem_addr, w, 32'(4 * writes));
          end
        end
        writes++;
      end
      if (in_valid && in_ready) sb.push_back(raw);
      @(posedge clk);
      @(negedge clk);
      got_done = done;
    end
    in_valid = 1'b0;
    checks++;
    if (!got_done || writes !== 12 || sb.size() !== 0) begin
      fails++;
      $display("FAIL b2b_end: got done=%b writes=%0d left=%0d want 1 12 0",
               got_done, writes, sb.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    mem_ready = 1'b0;
    fmt = 2'b00; op = '0; rs = '0; rt = '0; rd = '0;
    shamt = '0; funct = '0; immi = '0; immj = '0; raw = '0;
    test_reset();
    test_rtype();
    test_mixed();
    test_backpressure();
    test_capacity();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
